// File: rtl/leaf_user_port_adapter.sv
// Buffered, parametrised port stage between leaf_interface user-side ports and a user kernel.
// Per-channel FIFOs in both directions, ap_start arming, synchronous flush, saturating counters.

module leaf_upa_fifo #(
    parameter int W  = 32,
    parameter int AB = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    output logic         push_rdy_o,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    input  logic         pop_rdy_i
);
    localparam int DEPTH = 1 << AB;
    localparam int PW    = (AB > 0) ? AB : 1;
    localparam int CW    = AB + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push, pop;

    // Ready looks only at the registered count: a full FIFO never accepts on the cycle it pops.
    assign push_rdy_o = en_i && (cnt_q < CW'(DEPTH));
    assign pop_vld_o  = (cnt_q != '0);
    assign pop_dat_o  = pop_vld_o ? mem_q[rd_q] : '0;
    assign push       = push_vld_i && push_rdy_o;
    assign pop        = pop_vld_o && pop_rdy_i;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (pop)  rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_i) mem_q[wr_q] <= push_dat_i;
    end
endmodule

module leaf_user_port_adapter #(
    parameter int NUM_IN_PORTS   = 5,
    parameter int NUM_OUT_PORTS  = 1,
    parameter int PAYLOAD_BITS   = 32,
    parameter int FIFO_ADDR_BITS = 2,
    parameter int CNT_BITS       = 16
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    ap_start,
    input  logic                                    flush,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_user,
    output logic [NUM_IN_PORTS-1:0]                 vld_user,
    input  logic [NUM_IN_PORTS-1:0]                 rdy_user,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
    input  logic [NUM_OUT_PORTS-1:0]                vld_from_user,
    output logic [NUM_OUT_PORTS-1:0]                rdy_to_user,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    output logic                                    running,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]        in_word_cnt,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]       out_word_cnt
);
    logic running_q, running_d;

    // flush wins over ap_start; ap_start while already running is a no-op.
    always_comb begin
        running_d = running_q;
        if (flush)         running_d = 1'b0;
        else if (ap_start) running_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) running_q <= 1'b0;
        else       running_q <= running_d;
    end

    assign running = running_q;

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        logic [CNT_BITS-1:0] cnt_q, cnt_d;

        leaf_upa_fifo #(.W(PAYLOAD_BITS), .AB(FIFO_ADDR_BITS)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .en_i       (running_q),
            .flush_i    (flush),
            .push_vld_i (vld_interface2user[i]),
            .push_dat_i (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .push_rdy_o (ack_user2interface[i]),
            .pop_vld_o  (vld_user[i]),
            .pop_dat_o  (dout_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop_rdy_i  (rdy_user[i])
        );

        always_comb begin
            cnt_d = cnt_q;
            if (flush) cnt_d = '0;
            else if (vld_interface2user[i] && ack_user2interface[i] && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign in_word_cnt[i*CNT_BITS +: CNT_BITS] = cnt_q;
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        logic [CNT_BITS-1:0] cnt_q, cnt_d;

        leaf_upa_fifo #(.W(PAYLOAD_BITS), .AB(FIFO_ADDR_BITS)) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .en_i       (running_q),
            .flush_i    (flush),
            .push_vld_i (vld_from_user[j]),
            .push_dat_i (din_user[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .push_rdy_o (rdy_to_user[j]),
            .pop_vld_o  (vld_user2interface[j]),
            .pop_dat_o  (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .pop_rdy_i  (ack_interface2user[j])
        );

        always_comb begin
            cnt_d = cnt_q;
            if (flush) cnt_d = '0;
            else if (vld_user2interface[j] && ack_interface2user[j] && (cnt_q != '1))
                cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) cnt_q <= '0;
            else       cnt_q <= cnt_d;
        end

        assign out_word_cnt[j*CNT_BITS +: CNT_BITS] = cnt_q;
    end
endmodule

// File: tb/tb_leaf_user_port_adapter.sv
// Directed bench for leaf_user_port_adapter (5 in / 1 out, 32-bit, depth 4, 4-bit counters).

module tb_leaf_user_port_adapter;
    localparam int NI = 5;
    localparam int NO = 1;
    localparam int PB = 32;
    localparam int CB = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               ap_start;
    logic               flush;
    logic [NI*PB-1:0]   dout_l2i;
    logic [NI-1:0]      vld_i2u;
    logic [NI-1:0]      ack_u2i;
    logic [NI*PB-1:0]   dout_user;
    logic [NI-1:0]      vld_user;
    logic [NI-1:0]      rdy_user;
    logic [NO*PB-1:0]   din_user;
    logic [NO-1:0]      vld_from_user;
    logic [NO-1:0]      rdy_to_user;
    logic [NO*PB-1:0]   din_u2i;
    logic [NO-1:0]      vld_u2i;
    logic [NO-1:0]      ack_i2u;
    logic               running;
    logic [NI*CB-1:0]   in_cnt;
    logic [NO*CB-1:0]   out_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    leaf_user_port_adapter #(
        .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .PAYLOAD_BITS(PB),
        .FIFO_ADDR_BITS(2), .CNT_BITS(CB)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .ap_start                 (ap_start),
        .flush                    (flush),
        .dout_leaf_interface2user (dout_l2i),
        .vld_interface2user       (vld_i2u),
        .ack_user2interface       (ack_u2i),
        .dout_user                (dout_user),
        .vld_user                 (vld_user),
        .rdy_user                 (rdy_user),
        .din_user                 (din_user),
        .vld_from_user            (vld_from_user),
        .rdy_to_user              (rdy_to_user),
        .din_leaf_user2interface  (din_u2i),
        .vld_user2interface       (vld_u2i),
        .ack_interface2user       (ack_i2u),
        .running                  (running),
        .in_word_cnt              (in_cnt),
        .out_word_cnt             (out_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sent, rcv, cyc;
        logic prev_hold;

        reset = 1'b1; ap_start = 1'b0; flush = 1'b0;
        dout_l2i = '0; vld_i2u = '0; rdy_user = '0;
        din_user = '0; vld_from_user = '0; ack_i2u = '0;
        #2;
        chk("rst_running", 64'(running), 64'd0);
        chk("rst_vld_user", 64'(vld_user), 64'd0);
        chk("rst_vld_u2i", 64'(vld_u2i), 64'd0);
        #10 reset = 1'b0;

        // 1: not armed, interface valid everywhere -> no acks, no counts
        tick();
        vld_i2u = 5'h1F;
        dout_l2i = {5{32'hDEAD_BEEF}};
        #1;
        chk("t1_ack", 64'(ack_u2i), 64'd0);
        chk("t1_rdy_to_user", 64'(rdy_to_user), 64'd0);
        tick();
        chk("t1_in_cnt", 64'(in_cnt), 64'd0);
        chk("t1_vld_user", 64'(vld_user), 64'd0);
        vld_i2u = '0;

        // 2: arm, single word on ch0
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        #1;
        chk("t2_running", 64'(running), 64'd1);
        chk("t2_ack_all", 64'(ack_u2i), 64'h1F);
        dout_l2i[0 +: PB] = 32'hA5A5_0001;
        vld_i2u[0] = 1'b1;
        rdy_user = 5'h1F;
        #1;
        chk("t2_no_bypass", 64'(vld_user[0]), 64'd0);
        tick();
        vld_i2u[0] = 1'b0;
        #1;
        chk("t2_vld_user0", 64'(vld_user[0]), 64'd1);
        chk("t2_dout0", 64'(dout_user[0 +: PB]), 64'hA5A5_0001);
        chk("t2_in_cnt0", 64'(in_cnt[0 +: CB]), 64'd1);
        tick();
        chk("t2_popped", 64'(vld_user[0]), 64'd0);

        // 3: ch2 kernel stalled, fill to 4 then drain in order
        rdy_user[2] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dout_l2i[2*PB +: PB] = 32'h10 + 32'(k);
            vld_i2u[2] = 1'b1;
            #1;
            chk("t3_ack_fill", 64'(ack_u2i[2]), 64'd1);
            tick();
        end
        dout_l2i[2*PB +: PB] = 32'h14;
        #1;
        chk("t3_ack_full", 64'(ack_u2i[2]), 64'd0);
        tick();
        chk("t3_ack_full2", 64'(ack_u2i[2]), 64'd0);
        chk("t3_cnt4", 64'(in_cnt[2*CB +: CB]), 64'd4);
        rdy_user[2] = 1'b1;
        #1;
        chk("t3_d10", 64'(dout_user[2*PB +: PB]), 64'h10);
        chk("t3_no_popthru", 64'(ack_u2i[2]), 64'd0);
        tick();
        chk("t3_d11", 64'(dout_user[2*PB +: PB]), 64'h11);
        chk("t3_ack_reopen", 64'(ack_u2i[2]), 64'd1);
        tick();
        dout_l2i[2*PB +: PB] = 32'h15;
        #1;
        chk("t3_d12", 64'(dout_user[2*PB +: PB]), 64'h12);
        chk("t3_ack_steady", 64'(ack_u2i[2]), 64'd1);
        tick();
        vld_i2u[2] = 1'b0;
        #1;
        chk("t3_d13", 64'(dout_user[2*PB +: PB]), 64'h13);
        tick();
        chk("t3_d14", 64'(dout_user[2*PB +: PB]), 64'h14);
        tick();
        chk("t3_d15", 64'(dout_user[2*PB +: PB]), 64'h15);
        tick();
        chk("t3_empty", 64'(vld_user[2]), 64'd0);
        chk("t3_cnt6", 64'(in_cnt[2*CB +: CB]), 64'd6);

        // 4: output ch0, 8 words, interface acks every other cycle
        sent = 0; rcv = 0; cyc = 0; prev_hold = 1'b0;
        while (rcv < 8 && cyc < 100) begin
            ack_i2u[0]       = cyc[0];
            vld_from_user[0] = (sent < 8);
            din_user         = 32'h100 + 32'(sent);
            #1;
            if (prev_hold) chk("t4_vld_held", 64'(vld_u2i[0]), 64'd1);
            if (vld_u2i[0]) chk("t4_data", 64'(din_u2i), 64'h100 + 64'(rcv));
            prev_hold = vld_u2i[0] && !ack_i2u[0];
            if (vld_u2i[0] && ack_i2u[0]) rcv++;
            if (vld_from_user[0] && rdy_to_user[0]) sent++;
            tick();
            cyc++;
        end
        vld_from_user = '0;
        ack_i2u = '0;
        #1;
        chk("t4_rcv8", 64'(rcv), 64'd8);
        chk("t4_out_cnt", 64'(out_cnt), 64'd8);

        // 5: ch3 holds 3 words, flush with concurrent push
        rdy_user[3] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            dout_l2i[3*PB +: PB] = 32'h30 + 32'(k);
            vld_i2u[3] = 1'b1;
            tick();
        end
        chk("t5_held", 64'(vld_user[3]), 64'd1);
        dout_l2i[3*PB +: PB] = 32'h33;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vld_i2u[3] = 1'b0;
        #1;
        chk("t5_vld_user", 64'(vld_user), 64'd0);
        chk("t5_running", 64'(running), 64'd0);
        chk("t5_in_cnt", 64'(in_cnt), 64'd0);
        chk("t5_out_cnt", 64'(out_cnt), 64'd0);
        chk("t5_ack", 64'(ack_u2i), 64'd0);
        ap_start = 1'b1;
        tick();
        ap_start = 1'b0;
        #1;
        chk("t5_ack_restored", 64'(ack_u2i), 64'h1F);
        chk("t5_discarded", 64'(vld_user[3]), 64'd0);

        // 6: 20 words on ch1 saturate 4-bit counter; then async reset mid-stream
        rdy_user = 5'h1F;
        for (int k = 0; k < 20; k++) begin
            dout_l2i[1*PB +: PB] = 32'h200 + 32'(k);
            vld_i2u[1] = 1'b1;
            #1;
            chk("t6_ack", 64'(ack_u2i[1]), 64'd1);
            tick();
        end
        vld_i2u[1] = 1'b0;
        #1;
        chk("t6_sat", 64'(in_cnt[1*CB +: CB]), 64'd15);
        chk("t6_ch0_cnt", 64'(in_cnt[0 +: CB]), 64'd0);
        rdy_user[1] = 1'b0;
        vld_i2u[1] = 1'b1;
        tick();
        tick();
        chk("t6_pre_rst_vld", 64'(vld_user[1]), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_arst_running", 64'(running), 64'd0);
        chk("t6_arst_ack", 64'(ack_u2i), 64'd0);
        chk("t6_arst_vld", 64'(vld_user), 64'd0);
        chk("t6_arst_dout", 64'(dout_user == '0), 64'd1);
        chk("t6_arst_cnt", 64'(in_cnt), 64'd0);
        vld_i2u = '0;
        #3 reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
